// File: rtl/cacode_search_sched.sv
// Acquisition search scheduler: walks an omega x code-phase grid for one
// C/A code generator, dwelling, reporting to the correlator and slewing between steps.
module cacode_search_sched #(
  parameter int OMEGA_W = 9,
  parameter int IDX_W   = 8,
  parameter int DWELL_W = 16,
  parameter int SLEW_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [9:0]         cfg_g1,
  input  logic [9:0]         cfg_g2,
  input  logic [OMEGA_W-1:0] cfg_omega_min,
  input  logic [OMEGA_W-1:0] cfg_omega_step,
  input  logic [IDX_W-1:0]   cfg_num_omega,
  input  logic [IDX_W-1:0]   cfg_num_cp,
  input  logic [DWELL_W-1:0] cfg_dwell_len,
  input  logic [SLEW_W-1:0]  cfg_slew_len,
  input  logic               result_ack,
  output logic [9:0]         g1,
  output logic [9:0]         g2,
  output logic               set_reg,
  output logic [OMEGA_W-1:0] nco_omega,
  output logic               dump,
  output logic               result_valid,
  output logic [IDX_W-1:0]   om_idx,
  output logic [IDX_W-1:0]   cp_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, LOAD, DWELL, REPORT, SLEW, DONE} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]   num_omega_r, num_cp_r;
  logic [DWELL_W-1:0] dwell_len_r, dwell_cnt;
  logic [SLEW_W-1:0]  slew_len_r, slew_cnt;
  logic [OMEGA_W-1:0] omega_cur, omega_step_r, omega_next;
  logic [OMEGA_W:0]   omega_sum;
  logic               dwell_last, slew_last, cp_more, om_more;

  // Lengths are latched already clamped to >=1 (except slew), so no underflow here.
  assign dwell_last = (dwell_cnt == dwell_len_r - DWELL_W'(1));
  assign slew_last  = (slew_cnt == slew_len_r - SLEW_W'(1));
  assign cp_more    = (cp_idx < num_cp_r - IDX_W'(1));
  assign om_more    = (om_idx < num_omega_r - IDX_W'(1));

  // Omega advance saturates at full scale instead of wrapping to a low bin.
  assign omega_sum  = {1'b0, omega_cur} + {1'b0, omega_step_r};
  assign omega_next = omega_sum[OMEGA_W] ? {OMEGA_W{1'b1}} : omega_sum[OMEGA_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = LOAD;
      LOAD:   state_nxt = DWELL;
      DWELL:  if (dwell_last) state_nxt = REPORT;
      REPORT: begin
        if (result_ack) begin
          if (cp_more)      state_nxt = (slew_len_r == '0) ? DWELL : SLEW;
          else if (om_more) state_nxt = LOAD;
          else              state_nxt = DONE;
        end
      end
      SLEW:   if (slew_last) state_nxt = DWELL;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_comb begin
    set_reg      = (state == LOAD);
    nco_omega    = (state == DWELL) ? omega_cur : '0;
    dump         = (state == DWELL) && dwell_last;
    result_valid = (state == REPORT);
    busy         = (state != IDLE);
    done         = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      g1           <= '0;
      g2           <= '0;
      num_omega_r  <= '0;
      num_cp_r     <= '0;
      dwell_len_r  <= '0;
      slew_len_r   <= '0;
      omega_step_r <= '0;
      omega_cur    <= '0;
      om_idx       <= '0;
      cp_idx       <= '0;
      dwell_cnt    <= '0;
      slew_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= (state == DWELL && state_nxt == DWELL) ? dwell_cnt + DWELL_W'(1) : '0;
      slew_cnt  <= (state == SLEW && state_nxt == SLEW) ? slew_cnt + SLEW_W'(1) : '0;
      if (abort) begin
        om_idx    <= '0;
        cp_idx    <= '0;
        omega_cur <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              g1           <= cfg_g1;
              g2           <= cfg_g2;
              num_omega_r  <= (cfg_num_omega == '0) ? IDX_W'(1) : cfg_num_omega;
              num_cp_r     <= (cfg_num_cp == '0) ? IDX_W'(1) : cfg_num_cp;
              dwell_len_r  <= (cfg_dwell_len == '0) ? DWELL_W'(1) : cfg_dwell_len;
              slew_len_r   <= cfg_slew_len;
              omega_step_r <= cfg_omega_step;
              omega_cur    <= cfg_omega_min;
              om_idx       <= '0;
              cp_idx       <= '0;
            end
          end
          REPORT: begin
            if (result_ack) begin
              if (cp_more) begin
                cp_idx <= cp_idx + IDX_W'(1);
              end else if (om_more) begin
                om_idx    <= om_idx + IDX_W'(1);
                cp_idx    <= '0;
                omega_cur <= omega_next;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cacode_search_sched.sv
// Directed bench for cacode_search_sched: one task per scenario, expected
// values hand-derived from the cycle timeline of the scheduler.
module tb_cacode_search_sched;

  logic       clk = 1'b0;
  logic       rst, start, abort, result_ack;
  logic [9:0] cfg_g1, cfg_g2;
  logic [8:0] cfg_omega_min, cfg_omega_step;
  logic [7:0] cfg_num_omega, cfg_num_cp;
  logic [15:0] cfg_dwell_len;
  logic [9:0] cfg_slew_len;
  logic [9:0] g1, g2;
  logic       set_reg, dump, result_valid, busy, done;
  logic [8:0] nco_omega;
  logic [7:0] om_idx, cp_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cacode_search_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_g1(cfg_g1), .cfg_g2(cfg_g2),
    .cfg_omega_min(cfg_omega_min), .cfg_omega_step(cfg_omega_step),
    .cfg_num_omega(cfg_num_omega), .cfg_num_cp(cfg_num_cp),
    .cfg_dwell_len(cfg_dwell_len), .cfg_slew_len(cfg_slew_len),
    .result_ack(result_ack),
    .g1(g1), .g2(g2), .set_reg(set_reg), .nco_omega(nco_omega), .dump(dump),
    .result_valid(result_valid), .om_idx(om_idx), .cp_idx(cp_idx),
    .busy(busy), .done(done)
  );

  task automatic set_cfg(input logic [9:0] a_g1, input logic [9:0] a_g2,
                         input logic [8:0] a_min, input logic [8:0] a_step,
                         input logic [7:0] a_nom, input logic [7:0] a_ncp,
                         input logic [15:0] a_dwell, input logic [9:0] a_slew);
    cfg_g1 = a_g1; cfg_g2 = a_g2; cfg_omega_min = a_min; cfg_omega_step = a_step;
    cfg_num_omega = a_nom; cfg_num_cp = a_ncp; cfg_dwell_len = a_dwell; cfg_slew_len = a_slew;
  endtask

  // Pulses start for one edge; returns at the negedge of the first LOAD cycle.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({g1, g2, set_reg, nco_omega, dump, result_valid, om_idx, cp_idx, busy, done} !== '0)
      begin errors++; $display("[TB] FAIL reset_outputs: got g1=%0h g2=%0h busy=%0b nco=%0d expected all 0", g1, g2, busy, nco_omega); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: busy=%0b expected 0", busy); end
  endtask

  task automatic test_single_bin();
    set_cfg(10'h3A5, 10'h1C7, 9'd37, 9'd0, 8'd1, 8'd1, 16'd4, 10'd0);
    result_ack = 1'b1;
    do_start();
    checks++;
    if (set_reg !== 1'b1 || nco_omega !== 9'd0)
      begin errors++; $display("[TB] FAIL single_load: set_reg=%0b nco=%0d expected 1 and 0", set_reg, nco_omega); end
    checks++;
    if (g1 !== 10'h3A5 || g2 !== 10'h1C7)
      begin errors++; $display("[TB] FAIL single_g: g1=%0h g2=%0h expected 3a5 1c7", g1, g2); end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (nco_omega !== 9'd37 || set_reg !== 1'b0)
        begin errors++; $display("[TB] FAIL single_dwell t+%0d: nco=%0d set_reg=%0b expected 37 0", k, nco_omega, set_reg); end
      checks++;
      if (dump !== logic'(k == 5))
        begin errors++; $display("[TB] FAIL single_dump t+%0d: dump=%0b expected %0b", k, dump, (k == 5)); end
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || nco_omega !== 9'd0 || dump !== 1'b0)
      begin errors++; $display("[TB] FAIL single_report: rv=%0b nco=%0d dump=%0b expected 1 0 0", result_valid, nco_omega, dump); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || result_valid !== 1'b0)
      begin errors++; $display("[TB] FAIL single_done: done=%0b rv=%0b expected 1 0", done, result_valid); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("[TB] FAIL single_idle: done=%0b busy=%0b expected 0 0", done, busy); end
    result_ack = 1'b0;
  endtask

  task automatic test_grid();
    int exp_om[6] = '{10, 10, 30, 30, 50, 50};
    int exp_oi[6] = '{0, 0, 1, 1, 2, 2};
    int exp_cp[6] = '{0, 1, 0, 1, 0, 1};
    int cyc = 1, ndump = 0, nset = 0, nzero = 0, done_at = 0;
    set_cfg(10'h001, 10'h002, 9'd10, 9'd20, 8'd3, 8'd2, 16'd3, 10'd5);
    result_ack = 1'b1;
    do_start();
    while (cyc <= 60 && done_at == 0) begin
      if (set_reg) nset++;
      if (dump) begin
        if (ndump < 6) begin
          checks++;
          if (nco_omega !== exp_om[ndump][8:0] || om_idx !== exp_oi[ndump][7:0] || cp_idx !== exp_cp[ndump][7:0])
            begin errors++; $display("[TB] FAIL grid_dump%0d: nco=%0d om=%0d cp=%0d expected %0d %0d %0d", ndump, nco_omega, om_idx, cp_idx, exp_om[ndump], exp_oi[ndump], exp_cp[ndump]); end
        end
        ndump++;
      end
      if (busy && !set_reg && !result_valid && !done && nco_omega == 9'd0) nzero++;
      if (done) done_at = cyc;
      if (done_at == 0) begin @(negedge clk); cyc++; end
    end
    checks++;
    if (nset != 3) begin errors++; $display("[TB] FAIL grid_set_reg: got %0d pulses expected 3", nset); end
    checks++;
    if (ndump != 6) begin errors++; $display("[TB] FAIL grid_dumps: got %0d expected 6", ndump); end
    checks++;
    if (nzero != 15) begin errors++; $display("[TB] FAIL grid_slew_cycles: got %0d expected 15", nzero); end
    checks++;
    if (done_at != 43) begin errors++; $display("[TB] FAIL grid_done_time: got t+%0d expected t+43", done_at); end
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  task automatic test_report_hold();
    int b = 0;
    set_cfg(10'h0F0, 10'h00F, 9'd60, 9'd0, 8'd1, 8'd2, 16'd2, 10'd0);
    result_ack = 1'b0;
    do_start();
    while (!result_valid && b < 20) begin @(negedge clk); b++; end
    checks++;
    if (b != 3) begin errors++; $display("[TB] FAIL hold_report_entry: got t+%0d expected t+4", b + 1); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (result_valid !== 1'b1 || nco_omega !== 9'd0 || cp_idx !== 8'd0 || om_idx !== 8'd0 || dump !== 1'b0)
        begin errors++; $display("[TB] FAIL hold_cycle%0d: rv=%0b nco=%0d cp=%0d expected 1 0 0", i, result_valid, nco_omega, cp_idx); end
      if (i < 6) @(negedge clk);
    end
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || cp_idx !== 8'd1 || nco_omega !== 9'd60)
      begin errors++; $display("[TB] FAIL hold_advance: rv=%0b cp=%0d nco=%0d expected 0 1 60", result_valid, cp_idx, nco_omega); end
    b = 0;
    while (!result_valid && b < 20) begin @(negedge clk); b++; end
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL hold_done: done=%0b expected 1", done); end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    int exp_om[3] = '{500, 508, 511};
    int cyc = 0, ndump = 0;
    logic seen_done = 1'b0;
    set_cfg(10'h155, 10'h0AA, 9'd500, 9'd8, 8'd3, 8'd1, 16'd1, 10'd0);
    result_ack = 1'b1;
    do_start();
    while (cyc < 30 && !seen_done) begin
      if (dump) begin
        if (ndump < 3) begin
          checks++;
          if (nco_omega !== exp_om[ndump][8:0])
            begin errors++; $display("[TB] FAIL sat_omega%0d: got %0d expected %0d", ndump, nco_omega, exp_om[ndump]); end
        end
        ndump++;
      end
      if (done) seen_done = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    checks++;
    if (ndump != 3 || !seen_done)
      begin errors++; $display("[TB] FAIL sat_complete: dumps=%0d done=%0b expected 3 1", ndump, seen_done); end
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  task automatic test_abort_restart();
    set_cfg(10'h111, 10'h222, 9'd100, 9'd0, 8'd2, 8'd1, 16'd10, 10'd0);
    result_ack = 1'b1;
    do_start();
    @(negedge clk);
    set_cfg(10'h0AA, 10'h155, 9'd200, 9'd0, 8'd1, 8'd1, 16'd4, 10'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (set_reg !== 1'b0 || nco_omega !== 9'd100 || g1 !== 10'h111 || busy !== 1'b1)
      begin errors++; $display("[TB] FAIL busy_start_ignored: set_reg=%0b nco=%0d g1=%0h expected 0 100 111", set_reg, nco_omega, g1); end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || nco_omega !== 9'd0 || om_idx !== 8'd0 || cp_idx !== 8'd0 || set_reg !== 1'b0)
      begin errors++; $display("[TB] FAIL abort_idle: busy=%0b nco=%0d set_reg=%0b expected 0 0 0", busy, nco_omega, set_reg); end
    checks++;
    if (g1 !== 10'h111 || g2 !== 10'h222)
      begin errors++; $display("[TB] FAIL abort_g_hold: g1=%0h g2=%0h expected 111 222", g1, g2); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (set_reg !== 1'b1 || g1 !== 10'h0AA || g2 !== 10'h155)
      begin errors++; $display("[TB] FAIL restart_load: set_reg=%0b g1=%0h g2=%0h expected 1 0aa 155", set_reg, g1, g2); end
    @(negedge clk);
    checks++;
    if (nco_omega !== 9'd200) begin errors++; $display("[TB] FAIL restart_omega: got %0d expected 200", nco_omega); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    result_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_cfg(10'h2F0, 10'h10F, 9'd45, 9'd0, 8'd1, 8'd1, 16'd8, 10'd0);
    do_start();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (g1 !== 10'd0 || g2 !== 10'd0 || busy !== 1'b0 || nco_omega !== 9'd0)
      begin errors++; $display("[TB] FAIL reset_mid: g1=%0h g2=%0h busy=%0b nco=%0d expected 0 0 0 0", g1, g2, busy, nco_omega); end
    @(negedge clk);
  endtask

  task automatic test_zero_cfg();
    set_cfg(10'h00C, 10'h0C0, 9'd7, 9'd3, 8'd0, 8'd0, 16'd0, 10'd0);
    result_ack = 1'b1;
    do_start();
    checks++;
    if (set_reg !== 1'b1) begin errors++; $display("[TB] FAIL zero_load: set_reg=%0b expected 1", set_reg); end
    @(negedge clk);
    checks++;
    if (nco_omega !== 9'd7 || dump !== 1'b1)
      begin errors++; $display("[TB] FAIL zero_dwell: nco=%0d dump=%0b expected 7 1", nco_omega, dump); end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_report: rv=%0b expected 1", result_valid); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || set_reg !== 1'b0)
      begin errors++; $display("[TB] FAIL zero_done: done=%0b set_reg=%0b expected 1 0", done, set_reg); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle: busy=%0b expected 0", busy); end
    result_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; result_ack = 1'b0;
    set_cfg(10'd0, 10'd0, 9'd0, 9'd0, 8'd0, 8'd0, 16'd0, 10'd0);
    @(negedge clk);
    test_reset();
    test_single_bin();
    test_grid();
    test_report_hold();
    test_saturate();
    test_abort_restart();
    test_reset_mid();
    test_zero_cfg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
